// File: rtl/cbus_mem_responder.sv
// cbus memory-side responder: word-addressed backing store answering
// INCR/FIXED/WRAP bursts of 1-16 beats after a programmable initial latency.

package cbus_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } cbus_burst_e;

  typedef enum logic [3:0] {
    MLEN1,  MLEN2,  MLEN3,  MLEN4,  MLEN5,  MLEN6,  MLEN7,  MLEN8,
    MLEN9,  MLEN10, MLEN11, MLEN12, MLEN13, MLEN14, MLEN15, MLEN16
  } cbus_len_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    cbus_len_e   len;
    cbus_burst_e burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 1,
  parameter int unsigned IDX_BITS   = $clog2(MEM_WORDS)
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned WMAX = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int unsigned WCW  = (WMAX > 1) ? $clog2(WMAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } state_t;

  state_t               state, state_n;
  logic [WCW-1:0]       wait_cnt;
  logic [3:0]           beat_cnt;
  logic                 cap_wr;
  logic [IDX_BITS-1:0]  cap_base;
  logic [3:0]           cap_len;
  cbus_burst_e          cap_burst;

  logic                 start;
  logic                 mem_we;
  logic [IDX_BITS-1:0]  cur_idx;
  logic [IDX_BITS-1:0]  incr_idx;
  logic [IDX_BITS-1:0]  wrap_mask;
  logic                 len_pow2;

  logic [63:0] mem [MEM_WORDS];

  // Beat address: INCR/FIXED/WRAP; WRAP with a non-power-of-two length behaves as INCR
  always_comb begin
    incr_idx  = cap_base + IDX_BITS'(beat_cnt);
    wrap_mask = IDX_BITS'(cap_len);
    len_pow2  = ((cap_len & (cap_len + 4'd1)) == 4'd0);
    cur_idx   = incr_idx;
    if (cap_burst == BURST_FIXED) begin
      cur_idx = cap_base;
    end else if ((cap_burst == BURST_WRAP) && len_pow2) begin
      cur_idx = (cap_base & ~wrap_mask) | (incr_idx & wrap_mask);
    end
  end

  // Next-state and response outputs
  always_comb begin
    state_n = state;
    start   = 1'b0;
    mem_we  = 1'b0;
    cresp   = '0;
    unique case (state)
      ST_IDLE: begin
        if (creq.valid) begin
          start = 1'b1;
          if ((creq.is_write ? WRITE_WAIT : READ_WAIT) == 0) state_n = ST_BURST;
          else                                               state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!creq.valid)          state_n = ST_IDLE;
        else if (wait_cnt == '0)  state_n = ST_BURST;
      end
      ST_BURST: begin
        cresp.ready = 1'b1;
        cresp.last  = (beat_cnt == cap_len);
        cresp.data  = cap_wr ? '0 : mem[cur_idx];
        mem_we      = cap_wr && creq.valid;
        if (!creq.valid || cresp.last) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register, request capture and beat/wait counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      beat_cnt  <= '0;
      cap_wr    <= 1'b0;
      cap_base  <= '0;
      cap_len   <= '0;
      cap_burst <= BURST_FIXED;
    end else begin
      state <= state_n;
      if (start) begin
        cap_wr    <= creq.is_write;
        cap_base  <= creq.addr[3 +: IDX_BITS];
        cap_len   <= creq.len;
        cap_burst <= creq.burst;
        beat_cnt  <= '0;
        // Loaded with wait-1 so the WAIT state lasts exactly READ_WAIT/WRITE_WAIT cycles
        wait_cnt  <= creq.is_write ? WCW'(WRITE_WAIT - 1) : WCW'(READ_WAIT - 1);
      end else if (state == ST_WAIT) begin
        if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
      end else if (state == ST_BURST) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  // Byte-strobed write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (creq.strobe[i]) mem[cur_idx][8*i +: 8] <= creq.data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed and randomized bursts against an array-based memory model.
module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int unsigned MW = 256;
  localparam int unsigned RW = 2;
  localparam int unsigned WW = 1;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  cbus_mem_responder #(
    .MEM_WORDS (MW),
    .READ_WAIT (RW),
    .WRITE_WAIT(WW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .creq (creq),
    .cresp(cresp)
  );

  always #5 clk = ~clk;

  logic [63:0] model [MW];
  logic [63:0] wdata [16];
  logic [7:0]  wstrb [16];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word visited on beat k of an n-beat burst
  function automatic int ref_idx(input int base, input int k, input int n, input int b);
    int start;
    if (b == int'(BURST_FIXED)) return base;
    if (b == int'(BURST_WRAP) && ((n & (n - 1)) == 0)) begin
      start = base - (base % n);
      return start + ((base + k) % n);
    end
    return (base + k) % MW;
  endfunction

  // Issue one burst from a negedge; optionally keep valid for a back-to-back
  // follow-up, or pull reset right after beat rst_after commits.
  task automatic run_burst(input bit wr, input logic [63:0] addr, input int len,
                           input int b, input int exp_lat, input bit hold,
                           input int rst_after);
    int n, base, k, cyc, idx;
    n = len + 1;
    base = int'((addr >> 3) % MW);
    k = 0;
    cyc = 0;
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = 3'd3;
    creq.addr     = addr;
    creq.len      = cbus_len_e'(4'(len));
    creq.burst    = cbus_burst_e'(2'(b));
    creq.strobe   = '0;
    creq.data     = '0;
    while (k < n) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc > 60) begin
        checks++;
        errors++;
        $error("FAIL timeout observed=%0d beats expected=%0d", k, n);
        break;
      end
      if (!cresp.ready) begin
        chk("not_ready_zero", cresp, '0);
        continue;
      end
      if (k == 0) chk("latency", cyc, exp_lat);
      idx = ref_idx(base, k, n, b);
      chk("last", cresp.last, (k == n - 1));
      if (wr) begin
        chk("wr_data_zero", cresp.data, '0);
        creq.data   = wdata[k];
        creq.strobe = wstrb[k];
        for (int i = 0; i < 8; i++)
          if (wstrb[k][i]) model[idx][8*i +: 8] = wdata[k][8*i +: 8];
      end else begin
        chk("rd_data", cresp.data, model[idx]);
      end
      k++;
      if (rst_after >= 0 && k == rst_after + 1) begin
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("reset_mid_burst", cresp, '0);
        @(negedge clk);
        creq.valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        return;
      end
    end
    if (!hold) begin
      @(posedge clk);
      #1 creq.valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    bit wr;
    int len, b;
    logic [63:0] a;

    reset = 1'b0;
    creq  = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", cresp, '0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", cresp, '0);

    // Fill the whole store with known random words
    for (int blk = 0; blk < int'(MW / 16); blk++) begin
      for (int k = 0; k < 16; k++) begin
        wdata[k] = {$urandom, $urandom};
        wstrb[k] = 8'hFF;
      end
      run_burst(1'b1, 64'(blk * 128), 15, int'(BURST_INCR), WW + 1, 1'b0, -1);
    end

    // mem[16..31] = 0x1000 + i
    for (int k = 0; k < 16; k++) begin
      wdata[k] = 64'h1010 + 64'(k);
      wstrb[k] = 8'hFF;
    end
    run_burst(1'b1, 64'h80, 15, int'(BURST_INCR), WW + 1, 1'b0, -1);
    chk("preload_model", model[19], 64'h1013);

    run_burst(1'b0, 64'h80, 15, int'(BURST_INCR), RW + 1, 1'b0, -1);
    run_burst(1'b0, 64'h98, 15, int'(BURST_WRAP), RW + 1, 1'b0, -1);

    // Partial-strobe write then read back
    for (int k = 0; k < 4; k++) begin
      wdata[k] = 64'hAAAA_AAAA_AAAA_AAA0 + 64'(k);
      wstrb[k] = (k == 1) ? 8'h0F : 8'hFF;
    end
    run_burst(1'b1, 64'h200, 3, int'(BURST_INCR), WW + 1, 1'b0, -1);
    run_burst(1'b0, 64'h200, 3, int'(BURST_INCR), RW + 1, 1'b0, -1);

    // mem[2] = 0xDEAD, then FIXED read
    wdata[0] = 64'hDEAD;
    wstrb[0] = 8'hFF;
    run_burst(1'b1, 64'h10, 0, int'(BURST_INCR), WW + 1, 1'b0, -1);
    run_burst(1'b0, 64'h10, 3, int'(BURST_FIXED), RW + 1, 1'b0, -1);

    // Reset after beat 5 of a 16-beat write, then confirm contents
    for (int k = 0; k < 16; k++) begin
      wdata[k] = {$urandom, $urandom};
      wstrb[k] = 8'hFF;
    end
    run_burst(1'b1, 64'h400, 15, int'(BURST_INCR), WW + 1, 1'b0, 5);
    run_burst(1'b0, 64'h400, 15, int'(BURST_INCR), RW + 1, 1'b0, -1);

    // Back-to-back single reads with valid held throughout
    run_burst(1'b0, 64'h0, 0, int'(BURST_INCR), RW + 1, 1'b1, -1);
    run_burst(1'b0, 64'h8, 0, int'(BURST_INCR), RW + 2, 1'b0, -1);

    // Randomized mix, full 64-bit addresses exercise the modulo index
    for (int t = 0; t < 30; t++) begin
      wr  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(0, 15));
      b   = int'($urandom_range(0, 2));
      a   = {$urandom, $urandom};
      for (int k = 0; k < 16; k++) begin
        wdata[k] = {$urandom, $urandom};
        wstrb[k] = 8'($urandom);
      end
      run_burst(wr, a, len, b, wr ? int'(WW + 1) : int'(RW + 1), 1'b0, -1);
    end

    // Sweep the whole store once more
    for (int blk = 0; blk < int'(MW / 16); blk++)
      run_burst(1'b0, 64'(blk * 128), 15, int'(BURST_INCR), RW + 1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
